alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
// - Integer execute stage directly downstream of the reservation station.
// - Takes one ready RV32I ALU/branch/jump micro-op per cycle, computes it, and registers the result.
// - Broadcasts the result on the CDB-style bus (alu_ready/alu_result/alu_rob_index) back to the RS, LSB and ROB.
// - Also gives the ROB the resolved branch direction and target for misprediction recovery.
// PARAMETERS
// - CNT_W     32  width of the debug performance counters (wrap modulo 2^CNT_W)
// PORTS
// - clk_in            in   1   clock; all state updates on rising edge
// - rst_in            in   1   reset, asynchronous, active-low
// - rdy_in            in   1   global enable; low = hold every register
// - clr_in            in   1   synchronous flush (mispredict); kills the in-flight op
// - in_ready          in   1   RS presents a valid op this cycle
// - in_op             in   OPENUM  decoded op enum
// - in_rs1            in   32  operand 1 value
// - in_rs2            in   32  operand 2 value
// - in_imm            in   32  sign-extended immediate (pre-shifted for LUI/AUIPC)
// - in_pc             in   32  instruction PC
// - in_rob_index      in   ROB_INDEX  destination ROB tag (never 0; 0 = "no dependency")
// - alu_ready         out  1   result valid, one cycle per op
// - alu_result        out  32  rd write value
// - alu_rob_index     out  ROB_INDEX  tag of the result
// - alu_jump          out  1   1 = control transfer taken
// - alu_target        out  32  next PC: target if taken, else pc+4
// - exec_cnt          out  CNT_W  ops completed (debug)
// - taken_cnt         out  CNT_W  taken branches/jumps completed (debug)
// BEHAVIOUR
// - Reset (rst_in==0, any time, async): every output and counter = 0; no op in flight after release.
// - Priority each edge: reset > clr_in > !rdy_in (hold all) > normal.
// - clr_in=1: alu_ready<=0; the other outputs are don't-care; counters unchanged; the input op that cycle is dropped.
// - Normal: alu_ready<=in_ready; when in_ready, all outputs load from this cycle's inputs. Latency exactly 1 cycle. Throughput 1/cycle. No backpressure: the unit never stalls the RS.
// - in_ready=0: alu_ready<=0; data outputs hold their previous value.
// - Arithmetic: all 32-bit modular; ADD/SUB/ADDI wrap silently.
// - Shifts use operand[4:0] only. SRA/SRAI are arithmetic.
// - SLT/SLTI/BLT/BGE are signed; SLTU/SLTIU/BLTU/BGEU are unsigned. SLTIU compares against the sign-extended imm as unsigned.
// - R-type uses rs1 op rs2. I-type uses rs1 op imm.
// - LUI: result=imm. AUIPC: result=pc+imm. Neither sets jump.
// - Branches: jump=cond; target=cond ? pc+imm : pc+4; result=0 (ROB ignores it).
// - JAL: result=pc+4, jump=1, target=pc+imm.
// - JALR: result=pc+4, jump=1, target=(rs1+imm)&~32'h1.
// - Non-control ops: jump=0, target=pc+4.
// - Ops not owned by this unit (loads/stores/NOP/unknown enum): result=0, jump=0, target=pc+4. alu_ready still follows in_ready, so the ROB never hangs.
// - Counters: exec_cnt+=1 on each accepted op; taken_cnt+=1 when the op sets jump. Both are gated by rdy_in and clr_in and wrap to 0 after all-ones.
// - Output must not combinationally depend on inputs; all outputs are registers.
// STRUCTURE
// - Shared package def.v: OPENUM_TYPE and op enum values, DATA_TYPE, ADDR_TYPE, ROB_INDEX_TYPE, TRUE/FALSE.
// - Sub-module alu_branch_cmp: combinational (op, rs1, rs2) -> taken, covering the six branch conditions. It is reused by any future second ALU.
// - The top holds the result mux, next-PC logic and the output/counter registers.
// TESTING
// - ADD rs1=32'h7FFFFFFF rs2=1 tag=5 -> next cycle alu_ready=1, result=32'h80000000, rob_index=5, jump=0, target=pc+4.
// - SRA rs1=32'h80000000 rs2=32'h24 -> result=32'hF8000000 (shamt 4); SRL same operands -> 32'h08000000.
// - BLT rs1=32'hFFFFFFFF rs2=1 pc=32'h100 imm=-8 -> jump=1, target=32'hF8. BLTU same operands -> jump=0, target=32'h104.
// - JALR rs1=32'h1001 imm=2 pc=32'h40 -> result=32'h44, jump=1, target=32'h1002; taken_cnt increments by 1.
// - Back-to-back ops with clr_in=1 on the second edge -> only the first op appears; alu_ready=0 the next cycle; exec_cnt=1.
// - rdy_in=0 for 3 cycles with in_ready=1 -> outputs frozen. Assert rst_in low mid-stream, asynchronously -> all outputs 0 immediately and after release.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// Shared types for the integer execute stage: op encoding, data/tag widths, result bundle.
package alu_exec_unit_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int ROB_W  = 5;
  localparam int OP_W   = 6;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ROB_W-1:0]  rob_idx_t;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 6'd0,
    OP_LUI   = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL  = 6'd3,  OP_JALR = 6'd4,
    OP_BEQ   = 6'd5,  OP_BNE   = 6'd6,  OP_BLT  = 6'd7,  OP_BGE  = 6'd8,
    OP_BLTU  = 6'd9,  OP_BGEU  = 6'd10,
    OP_LB    = 6'd11, OP_LH    = 6'd12, OP_LW   = 6'd13, OP_LBU  = 6'd14,
    OP_LHU   = 6'd15, OP_SB    = 6'd16, OP_SH   = 6'd17, OP_SW   = 6'd18,
    OP_ADDI  = 6'd19, OP_SLTI  = 6'd20, OP_SLTIU = 6'd21, OP_XORI = 6'd22,
    OP_ORI   = 6'd23, OP_ANDI  = 6'd24, OP_SLLI = 6'd25, OP_SRLI = 6'd26,
    OP_SRAI  = 6'd27,
    OP_ADD   = 6'd28, OP_SUB   = 6'd29, OP_SLL  = 6'd30, OP_SLT  = 6'd31,
    OP_SLTU  = 6'd32, OP_XOR   = 6'd33, OP_SRL  = 6'd34, OP_SRA  = 6'd35,
    OP_OR    = 6'd36, OP_AND   = 6'd37
  } op_e;

  typedef struct packed {
    data_t result;
    logic  jump;
    addr_t target;
  } exec_res_t;

endpackage

// File: rtl/alu_exec_unit_branch_cmp.sv
// Combinational branch-condition evaluator for the six conditional branches.
// Non-branch ops report not-taken.
module alu_branch_cmp
  import alu_exec_unit_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  output logic              taken
);

  always_comb begin
    taken = FALSE;
    case (op_e'(op))
      OP_BEQ:  taken = (rs1 == rs2);
      OP_BNE:  taken = (rs1 != rs2);
      OP_BLT:  taken = ($signed(rs1) < $signed(rs2));
      OP_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      OP_BLTU: taken = (rs1 < rs2);
      OP_BGEU: taken = (rs1 >= rs2);
      default: taken = FALSE;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// RV32I ALU/branch/jump execute stage; registers result, tag and resolved next-PC.
// Latency 1 cycle, one op per cycle; never backpressures the reservation station.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clr_in,
  input  logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_rs1,
  input  logic [DATA_W-1:0] in_rs2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ROB_W-1:0]  in_rob_index,
  output logic              alu_ready,
  output logic [DATA_W-1:0] alu_result,
  output logic [ROB_W-1:0]  alu_rob_index,
  output logic              alu_jump,
  output logic [ADDR_W-1:0] alu_target,
  output logic [CNT_W-1:0]  exec_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  op_e       op_sel;
  logic      br_taken;
  addr_t     pc_plus4;
  addr_t     pc_rel;
  exec_res_t res_d;
  exec_res_t res_q;
  rob_idx_t  rob_q;

  assign op_sel   = op_e'(in_op);
  assign pc_plus4 = in_pc + 32'd4;
  assign pc_rel   = in_pc + in_imm;

  alu_branch_cmp u_branch_cmp (
    .op    (in_op),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .taken (br_taken)
  );

  always_comb begin
    res_d        = '0;
    res_d.target = pc_plus4;
    case (op_sel)
      OP_LUI:   res_d.result = in_imm;
      OP_AUIPC: res_d.result = pc_rel;
      OP_JAL: begin
        res_d.result = pc_plus4;
        res_d.jump   = TRUE;
        res_d.target = pc_rel;
      end
      OP_JALR: begin
        res_d.result = pc_plus4;
        res_d.jump   = TRUE;
        res_d.target = (in_rs1 + in_imm) & ~32'h1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        res_d.jump   = br_taken;
        res_d.target = br_taken ? pc_rel : pc_plus4;
      end
      OP_ADDI:  res_d.result = in_rs1 + in_imm;
      OP_SLTI:  res_d.result = {31'b0, $signed(in_rs1) < $signed(in_imm)};
      OP_SLTIU: res_d.result = {31'b0, in_rs1 < in_imm};
      OP_XORI:  res_d.result = in_rs1 ^ in_imm;
      OP_ORI:   res_d.result = in_rs1 | in_imm;
      OP_ANDI:  res_d.result = in_rs1 & in_imm;
      OP_SLLI:  res_d.result = in_rs1 << in_imm[4:0];
      OP_SRLI:  res_d.result = in_rs1 >> in_imm[4:0];
      OP_SRAI:  res_d.result = $signed(in_rs1) >>> in_imm[4:0];
      OP_ADD:   res_d.result = in_rs1 + in_rs2;
      OP_SUB:   res_d.result = in_rs1 - in_rs2;
      OP_SLL:   res_d.result = in_rs1 << in_rs2[4:0];
      OP_SLT:   res_d.result = {31'b0, $signed(in_rs1) < $signed(in_rs2)};
      OP_SLTU:  res_d.result = {31'b0, in_rs1 < in_rs2};
      OP_XOR:   res_d.result = in_rs1 ^ in_rs2;
      OP_SRL:   res_d.result = in_rs1 >> in_rs2[4:0];
      OP_SRA:   res_d.result = $signed(in_rs1) >>> in_rs2[4:0];
      OP_OR:    res_d.result = in_rs1 | in_rs2;
      OP_AND:   res_d.result = in_rs1 & in_rs2;
      // loads, stores, NOP and unknown encodings still retire with a benign result
      default:  res_d = '{result: '0, jump: FALSE, target: pc_plus4};
    endcase
  end

  // Flush outranks the global stall so a mispredict always kills the pending valid.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      alu_ready <= 1'b0;
      res_q     <= '0;
      rob_q     <= '0;
      exec_cnt  <= '0;
      taken_cnt <= '0;
    end else if (clr_in) begin
      alu_ready <= 1'b0;
    end else if (rdy_in) begin
      alu_ready <= in_ready;
      if (in_ready) begin
        res_q    <= res_d;
        rob_q    <= in_rob_index;
        exec_cnt <= exec_cnt + CNT_W'(1);
        if (res_d.jump) taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

  assign alu_result    = res_q.result;
  assign alu_jump      = res_q.jump;
  assign alu_target    = res_q.target;
  assign alu_rob_index = rob_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and randomized bench for alu_exec_unit against an op-level reference model.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in, in_ready;
  logic [5:0]  in_op;
  logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
  logic [4:0]  in_rob_index;
  logic        alu_ready, alu_jump;
  logic [31:0] alu_result, alu_target, exec_cnt, taken_cnt;
  logic [4:0]  alu_rob_index;

  int n_vec = 0;
  int n_err = 0;

  // reference state
  logic        m_ready, m_jump, m_known;
  logic [31:0] m_result, m_target, m_exec, m_taken;
  logic [4:0]  m_rob;

  alu_exec_unit #(.CNT_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .in_ready(in_ready), .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_pc(in_pc), .in_rob_index(in_rob_index),
    .alu_ready(alu_ready), .alu_result(alu_result), .alu_rob_index(alu_rob_index),
    .alu_jump(alu_jump), .alu_target(alu_target),
    .exec_cnt(exec_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // RV32I semantics written straight from the ISA rules
  function automatic void ref_exec(input logic [5:0] opv, input logic [31:0] a, b, imm, pc,
                                   output logic [31:0] res, output logic jmp,
                                   output logic [31:0] tgt);
    logic [31:0] x;
    int          sa, sx;
    int unsigned sh;
    logic        is_br, cond;
    res = 0; jmp = 0; tgt = pc + 32'd4; is_br = 0; cond = 0;
    case (op_e'(opv))
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
      OP_SLLI, OP_SRLI, OP_SRAI: x = imm;
      default: x = b;
    endcase
    sa = a; sx = x; sh = x % 32;
    case (op_e'(opv))
      OP_LUI:            res = imm;
      OP_AUIPC:          res = pc + imm;
      OP_JAL:            begin res = pc + 4; jmp = 1; tgt = pc + imm; end
      OP_JALR:           begin res = pc + 4; jmp = 1; tgt = (a + imm) & 32'hFFFF_FFFE; end
      OP_BEQ:            begin is_br = 1; cond = (a == b); end
      OP_BNE:            begin is_br = 1; cond = (a != b); end
      OP_BLT:            begin is_br = 1; cond = (sa < int'(b)); end
      OP_BGE:            begin is_br = 1; cond = !(sa < int'(b)); end
      OP_BLTU:           begin is_br = 1; cond = (a < b); end
      OP_BGEU:           begin is_br = 1; cond = !(a < b); end
      OP_ADD, OP_ADDI:   res = a + x;
      OP_SUB:            res = a - x;
      OP_SLT, OP_SLTI:   res = (sa < sx) ? 32'd1 : 32'd0;
      OP_SLTU, OP_SLTIU: res = (a < x) ? 32'd1 : 32'd0;
      OP_XOR, OP_XORI:   res = a ^ x;
      OP_OR, OP_ORI:     res = a | x;
      OP_AND, OP_ANDI:   res = a & x;
      OP_SLL, OP_SLLI:   res = a * (32'd1 << sh);
      OP_SRL, OP_SRLI:   res = a / (32'd1 << sh);
      OP_SRA, OP_SRAI:   res = (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      default:           res = 0;
    endcase
    if (is_br) begin
      jmp = cond;
      tgt = cond ? pc + imm : pc + 32'd4;
    end
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".ready"}, {31'b0, alu_ready}, {31'b0, m_ready});
    if (m_known) begin
      chk({tag, ".result"}, alu_result, m_result);
      chk({tag, ".jump"},   {31'b0, alu_jump}, {31'b0, m_jump});
      chk({tag, ".target"}, alu_target, m_target);
      chk({tag, ".rob"},    {27'b0, alu_rob_index}, {27'b0, m_rob});
    end
    chk({tag, ".exec_cnt"},  exec_cnt,  m_exec);
    chk({tag, ".taken_cnt"}, taken_cnt, m_taken);
  endtask

  task automatic model_reset();
    m_ready = 0; m_jump = 0; m_known = 1; m_result = 0; m_target = 0;
    m_exec = 0; m_taken = 0; m_rob = 0;
  endtask

  // drive one cycle of inputs, advance past the edge, update model, compare
  task automatic step(input string tag, input logic rdy, clr, vld, input logic [5:0] op,
                      input logic [31:0] a, b, imm, pc, input logic [4:0] tg);
    logic [31:0] r, t;
    logic        j;
    rdy_in = rdy; clr_in = clr; in_ready = vld; in_op = op;
    in_rs1 = a; in_rs2 = b; in_imm = imm; in_pc = pc; in_rob_index = tg;
    @(posedge clk_in); #1;
    if (clr) begin
      m_ready = 0; m_known = 0;
    end else if (rdy) begin
      m_ready = vld;
      if (vld) begin
        ref_exec(op, a, b, imm, pc, r, j, t);
        m_result = r; m_jump = j; m_target = t; m_rob = tg; m_known = 1;
        m_exec = m_exec + 1;
        if (j) m_taken = m_taken + 1;
      end
    end
    check_outputs(tag);
  endtask

  initial begin
    logic [31:0] tk0, a, b;
    logic [5:0]  op;
    rst_in = 0; rdy_in = 0; clr_in = 0; in_ready = 0; in_op = 0;
    in_rs1 = 0; in_rs2 = 0; in_imm = 0; in_pc = 0; in_rob_index = 0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_outputs("reset");
    rst_in = 1;

    // flush on the second of two back-to-back ops
    step("b2b_first", 1, 0, 1, OP_ADD, 32'd3, 32'd4, 0, 32'h200, 5'd1);
    step("b2b_clr",   1, 1, 1, OP_SUB, 32'd9, 32'd4, 0, 32'h204, 5'd2);
    step("b2b_after", 1, 0, 0, OP_NOP, 0, 0, 0, 0, 5'd0);
    chk("b2b_exec_lit", exec_cnt, 32'd1);

    step("add_wrap", 1, 0, 1, OP_ADD, 32'h7FFF_FFFF, 32'd1, 0, 32'h10, 5'd5);
    chk("add_wrap_lit", alu_result, 32'h8000_0000);
    step("sra", 1, 0, 1, OP_SRA, 32'h8000_0000, 32'h24, 0, 32'h14, 5'd6);
    chk("sra_lit", alu_result, 32'hF800_0000);
    step("srl", 1, 0, 1, OP_SRL, 32'h8000_0000, 32'h24, 0, 32'h18, 5'd7);
    chk("srl_lit", alu_result, 32'h0800_0000);
    step("blt", 1, 0, 1, OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100, 5'd8);
    chk("blt_tgt_lit", alu_target, 32'hF8);
    step("bltu", 1, 0, 1, OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100, 5'd9);
    chk("bltu_tgt_lit", alu_target, 32'h104);
    tk0 = taken_cnt;
    step("jalr", 1, 0, 1, OP_JALR, 32'h1001, 0, 32'd2, 32'h40, 5'd10);
    chk("jalr_tgt_lit", alu_target, 32'h1002);
    chk("jalr_taken_inc", taken_cnt, tk0 + 32'd1);
    step("sltiu", 1, 0, 1, OP_SLTIU, 32'd5, 0, 32'hFFFF_FFFF, 32'h44, 5'd11);
    step("lui",   1, 0, 1, OP_LUI, 0, 0, 32'hABCD_E000, 32'h48, 5'd12);
    step("auipc", 1, 0, 1, OP_AUIPC, 0, 0, 32'h0000_1000, 32'h4C, 5'd13);
    step("jal",   1, 0, 1, OP_JAL, 0, 0, 32'hFFFF_FFF0, 32'h50, 5'd14);
    step("load",  1, 0, 1, OP_LW, 32'h55, 32'h66, 32'h4, 32'h54, 5'd15);
    step("unk",   1, 0, 1, 6'd63, 32'h55, 32'h66, 32'h4, 32'h58, 5'd16);
    step("idle",  1, 0, 0, OP_ADD, 32'h1, 32'h2, 0, 32'h5C, 5'd17);

    // stall with valid ops presented: everything frozen
    step("pre_stall", 1, 0, 1, OP_XOR, 32'hF0F0, 32'h0FF0, 0, 32'h60, 5'd18);
    for (int i = 0; i < 3; i++)
      step("stall", 0, 0, 1, OP_ADD, 32'h1234 + i, 32'h1, 0, 32'h64, 5'd19);

    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 19) == 0) ? 6'(40 + $urandom_range(0, 23)) : 6'($urandom_range(0, 37));
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = 32'($urandom_range(0, 7));
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      step("rand", $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 4) != 0, op, a, b, $urandom, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
           5'($urandom_range(1, 31)));
    end

    // asynchronous reset between edges
    step("pre_rst", 1, 0, 1, OP_JAL, 0, 0, 32'h20, 32'h80, 5'd3);
    #2 rst_in = 0;
    #1;
    model_reset();
    check_outputs("async_rst");
    in_ready = 1; rdy_in = 1; in_op = OP_JAL;
    @(posedge clk_in); #1;
    check_outputs("in_rst");
    #2 rst_in = 1;
    step("post_rst", 1, 0, 0, OP_ADD, 0, 0, 0, 0, 5'd0);
    step("post_rst_op", 1, 0, 1, OP_BEQ, 32'd7, 32'd7, 32'h10, 32'h90, 5'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
